// File: rtl/dual_port_ram.sv
// Simple dual-port RAM with lane write enables, selectable collision mode and a post-reset clear sequencer.
// Latency: read data and rvalid follow the sampled ren by 1+OUT_REG cycles; full one-read-per-cycle throughput.
// Backpressure: none; both ports are ignored (no rvalid, writes dropped) while busy is high during the clear.
module dual_port_ram #(
    parameter int SIZE           = 8,
    parameter int DEPTH          = 256,
    parameter int BYTE_W         = 8,
    parameter int MODE           = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LANES         = SIZE / BYTE_W,
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic [AW-1:0]    waddr,
    input  logic [SIZE-1:0]  wdata,
    input  logic [LANES-1:0] wen,
    input  logic [AW-1:0]    raddr,
    input  logic             ren,
    output logic [SIZE-1:0]  rdata,
    output logic             rvalid
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     cnt;

    logic              w_in;
    logic              r_in;
    logic              wr_ok;
    logic              rd_ok;
    logic [LANES-1:0]  mem_we;
    logic [AW-1:0]     mem_addr;
    logic [SIZE-1:0]   mem_wdat;

    logic [SIZE-1:0]   ram [0:DEPTH-1];

    logic [SIZE-1:0]   rd_q;
    logic              s1_vld;
    logic              hit;
    logic [LANES-1:0]  hit_wen;
    logic [SIZE-1:0]   hit_wdat;
    logic [SIZE-1:0]   s1_dat;

    // Addresses past DEPTH exist only when DEPTH is not a power of two.
    assign w_in  = {1'b0, waddr} < DEPTH_L;
    assign r_in  = {1'b0, raddr} < DEPTH_L;
    assign wr_ok = !rst && !busy && w_in;
    assign rd_ok = !rst && !busy && ren;

    // The clear sequencer shares the single write port with the user side.
    always_comb begin
        mem_we   = '0;
        mem_addr = waddr;
        mem_wdat = wdata;
        if (!rst && busy) begin
            mem_we   = '1;
            mem_addr = cnt;
            mem_wdat = '0;
        end else if (wr_ok) begin
            mem_we = wen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            busy  <= (CLEAR_ON_RESET != 0);
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we[i]) begin
                ram[mem_addr][i*BYTE_W +: BYTE_W] <= mem_wdat[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array read is always read-first; write-first is rebuilt from a registered bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            s1_vld   <= 1'b0;
            hit      <= 1'b0;
            hit_wen  <= '0;
            hit_wdat <= '0;
        end else begin
            s1_vld <= rd_ok;
            if (rd_ok) begin
                rd_q     <= r_in ? ram[raddr] : '0;
                hit      <= (MODE != 0) && r_in && wr_ok && (waddr == raddr) && (|wen);
                hit_wen  <= wen;
                hit_wdat <= wdata;
            end
        end
    end

    always_comb begin
        s1_dat = rd_q;
        for (int i = 0; i < LANES; i++) begin
            if (hit && hit_wen[i]) begin
                s1_dat[i*BYTE_W +: BYTE_W] = hit_wdat[i*BYTE_W +: BYTE_W];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             s2_vld;
            logic [SIZE-1:0]  s2_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign rdata  = s2_dat;
            assign rvalid = s2_vld;
        end else begin : g_noreg
            assign rdata  = s1_dat;
            assign rvalid = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench: read-first/no-outreg and write-first/outreg instances on shared stimulus, checked against a word-level model.
module tb_dual_port_ram;

    localparam int SIZE   = 16;
    localparam int DEPTH  = 10;
    localparam int BYTE_W = 8;
    localparam int LANES  = 2;
    localparam int AW     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    waddr;
    logic [SIZE-1:0]  wdata;
    logic [LANES-1:0] wen;
    logic [AW-1:0]    raddr;
    logic             ren;

    logic             busy_rf, busy_wf;
    logic [SIZE-1:0]  rdata_rf, rdata_wf;
    logic             rvalid_rf, rvalid_wf;

    always #5 clk = ~clk;

    dual_port_ram #(.SIZE(SIZE), .DEPTH(DEPTH), .BYTE_W(BYTE_W), .MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst(rst), .busy(busy_rf), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rdata_rf), .rvalid(rvalid_rf)
    );

    dual_port_ram #(.SIZE(SIZE), .DEPTH(DEPTH), .BYTE_W(BYTE_W), .MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst(rst), .busy(busy_wf), .waddr(waddr), .wdata(wdata), .wen(wen),
        .raddr(raddr), .ren(ren), .rdata(rdata_wf), .rvalid(rvalid_wf)
    );

    int tests = 0;
    int fails = 0;
    int n = 0;
    int clear_left = 0;
    int bc;

    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] held_rf = '0;
    logic [15:0] held_wf = '0;
    logic [15:0] due_rf [int];
    logic [15:0] due_wf [int];

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] en);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) begin
            if (en[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare outputs.
    task automatic tick();
        logic [15:0] old;
        logic        ev;
        @(posedge clk);
        n++;
        if (rst) begin
            clear_left = DEPTH;
            due_rf.delete();
            due_wf.delete();
            held_rf = '0;
            held_wf = '0;
        end else if (clear_left > 0) begin
            mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            if (ren) begin
                old = '0;
                if (int'(raddr) < DEPTH) old = mem[raddr];
                due_rf[n] = old;
                if (wen != 0 && waddr == raddr && int'(waddr) < DEPTH)
                    due_wf[n+1] = merge(old, wdata, wen);
                else
                    due_wf[n+1] = old;
            end
            if (int'(waddr) < DEPTH) mem[waddr] = merge(mem[waddr], wdata, wen);
        end
        #1;
        chk("busy_rf", 32'(busy_rf), 32'(clear_left > 0));
        chk("busy_wf", 32'(busy_wf), 32'(clear_left > 0));
        ev = due_rf.exists(n);
        if (ev) begin
            held_rf = due_rf[n];
            due_rf.delete(n);
        end
        chk("rvalid_rf", 32'(rvalid_rf), 32'(ev));
        chk("rdata_rf", 32'(rdata_rf), 32'(held_rf));
        ev = due_wf.exists(n);
        if (ev) begin
            held_wf = due_wf[n];
            due_wf.delete(n);
        end
        chk("rvalid_wf", 32'(rvalid_wf), 32'(ev));
        chk("rdata_wf", 32'(rdata_wf), 32'(held_wf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; waddr = '0; wdata = '0; wen = '0; raddr = '0; ren = 1'b0;

        // Clear after a 2-cycle reset
        tick(); tick();
        rst = 1'b0;
        bc = 0;
        do begin tick(); bc++; end while (busy_rf && bc < 30);
        chk("clear_len", 32'(bc), 32'd10);

        for (int i = 0; i < DEPTH; i++) begin
            ren = 1'b1; raddr = AW'(i);
            tick();
            chk("clear_rd", 32'(rdata_rf), 32'h0);
        end
        ren = 1'b0;
        tick(); tick();

        // Byte-lane write
        waddr = 4'd3; wdata = 16'hABCD; wen = 2'b11; tick();
        wdata = 16'h1234; wen = 2'b01; tick();
        wen = 2'b00; ren = 1'b1; raddr = 4'd3; tick();
        ren = 1'b0;
        chk("lane_rf", 32'(rdata_rf), 32'hAB34);
        tick();
        chk("lane_wf", 32'(rdata_wf), 32'hAB34);

        // Collision, full-word write
        waddr = 4'd5; wdata = 16'h0011; wen = 2'b11; tick();
        wdata = 16'h00FF; ren = 1'b1; raddr = 4'd5; tick();
        chk("coll_rf", 32'(rdata_rf), 32'h0011);
        wen = 2'b00; tick();
        chk("coll_rf_next", 32'(rdata_rf), 32'h00FF);
        chk("coll_wf", 32'(rdata_wf), 32'h00FF);

        // Collision, low lane only
        ren = 1'b0; wdata = 16'h0011; wen = 2'b11; tick();
        wdata = 16'h00FF; wen = 2'b01; ren = 1'b1; tick();
        chk("coll_lane_rf", 32'(rdata_rf), 32'h0011);
        ren = 1'b0; wen = 2'b00; tick();
        chk("coll_lane_wf", 32'(rdata_wf), 32'h00FF);

        // Output-register throughput
        for (int i = 0; i < 4; i++) begin
            waddr = AW'(i); wdata = 16'(32'hA000 + i); wen = 2'b11; tick();
        end
        wen = 2'b00;
        for (int k = 0; k < 7; k++) begin
            ren = (k < 4);
            raddr = (k < 4) ? AW'(k) : '0;
            tick();
            chk("thru_vld", 32'(rvalid_wf), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk("thru_dat", 32'(rdata_wf), 32'hA000 + 32'(k - 1));
        end

        // Out-of-range write dropped, read returns zero
        waddr = 4'd12; wdata = 16'hBEEF; wen = 2'b11; ren = 1'b1; raddr = 4'd12; tick();
        wen = 2'b00; ren = 1'b0;
        chk("oor_vld", 32'(rvalid_rf), 32'd1);
        chk("oor_dat", 32'(rdata_rf), 32'h0);
        tick();

        // Reset mid-clear, writes dropped while busy
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (6) tick();
        waddr = 4'd2; wdata = 16'h5555; wen = 2'b11;
        rst = 1'b1; tick();
        rst = 1'b0;
        bc = 0;
        do begin tick(); bc++; end while (busy_rf && bc < 30);
        chk("restart_len", 32'(bc), 32'd10);
        wen = 2'b00; ren = 1'b1; raddr = 4'd2; tick();
        ren = 1'b0;
        chk("lockout_rf", 32'(rdata_rf), 32'h0);
        tick();
        chk("lockout_wf", 32'(rdata_wf), 32'h0);

        // Randomised traffic including out-of-range addresses and rare resets
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            ren   = 1'($urandom_range(0, 1));
            wen   = 2'($urandom_range(0, 3));
            waddr = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            wdata = 16'($urandom);
            tick();
        end
        rst = 1'b0; ren = 1'b0; wen = 2'b00;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
